// File: rtl/arith_pkg.sv
// Shared encodings and sizing helpers for the bit-serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bit-counter width; never below one bit so WIDTH=2 still gets a real counter.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor; ovf exists only with SUB_OVF_EN.
import arith_pkg::*;

interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    // Both channels transfer on a rising edge where valid && ready; a producer holds its
    // payload stable while valid is high and ready is low, and never withdraws valid early.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif
    state_e           dbg_state;

`ifdef SUB_OVF_EN
    modport master (output in_valid, a, b, bin, out_ready,
                    input  in_ready, out_valid, diff, bout, ovf, dbg_state);
    modport slave  (input  in_valid, a, b, bin, out_ready,
                    output in_ready, out_valid, diff, bout, ovf, dbg_state);
`else
    modport master (output in_valid, a, b, bin, out_ready,
                    input  in_ready, out_valid, diff, bout, dbg_state);
    modport slave  (input  in_valid, a, b, bin, out_ready,
                    output in_ready, out_valid, diff, bout, dbg_state);
`endif

endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor a - b - bin, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output is built when SUB_OVF_EN is defined.
import arith_pkg::*;

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_brw;
    logic             r_bout;
    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;

    full_subtractor u_fs (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_brw),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (bus.in_valid)  w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last)        w_next_state = ST_DONE;
            ST_DONE:  if (bus.out_ready) w_next_state = ST_IDLE;
            default:                     w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_sh   <= '0;
            r_brw  <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_brw <= bus.bin;
            r_cnt <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_brw <= w_bout;
            r_sh  <= {w_d, r_sh[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
            // Result registers update only here so DONE presents a frozen value.
            if (w_last) begin
                r_diff <= {w_d, r_sh[WIDTH-1:1]};
                r_bout <= w_bout;
            end
        end
    end

`ifdef SUB_OVF_EN
    logic r_ovf;

    // On the MSB cycle r_brw is the borrow into the sign bit, w_bout the borrow out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ovf <= 1'b0;
        else if (w_last) r_ovf <= r_brw ^ w_bout;
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed WIDTH=4 cases, then random WIDTH=8 traffic.
import arith_pkg::*;

module tb_serial_subtractor;

    localparam int N_OPS = 1000;
    localparam int N_BB  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    bit         sel = 1'b0;
    logic       d_valid = 1'b0;
    logic       d_out_ready = 1'b0;
    logic [7:0] d_a = '0;
    logic [7:0] d_b = '0;
    logic       d_bin = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(4)) if4 ();
    serial_subtractor_if #(.WIDTH(8)) if8 ();

    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    assign if4.in_valid  = d_valid && !sel;
    assign if4.a         = d_a[3:0];
    assign if4.b         = d_b[3:0];
    assign if4.bin       = d_bin;
    assign if4.out_ready = d_out_ready && !sel;
    assign if8.in_valid  = d_valid && sel;
    assign if8.a         = d_a;
    assign if8.b         = d_b;
    assign if8.bin       = d_bin;
    assign if8.out_ready = d_out_ready && sel;

    logic       obs_in_ready;
    logic       obs_out_valid;
    logic [7:0] obs_diff;
    logic       obs_bout;
    assign obs_in_ready  = sel ? if8.in_ready  : if4.in_ready;
    assign obs_out_valid = sel ? if8.out_valid : if4.out_valid;
    assign obs_diff      = sel ? if8.diff      : {4'b0000, if4.diff};
    assign obs_bout      = sel ? if8.bout      : if4.bout;
`ifdef SUB_OVF_EN
    logic obs_ovf;
    assign obs_ovf = sel ? if8.ovf : if4.ovf;
`endif

    // Reference: plain integer arithmetic, returns {ovf, bout, diff[7:0]}.
    function automatic logic [9:0] ref_sub(input int w, input logic [7:0] a, input logic [7:0] b,
                                           input logic bin);
        int r, sa, sb, sr, mod;
        logic [9:0] res;
        mod = 1 << w;
        r   = int'(a) - int'(b) - int'(bin);
        sa  = (int'(a) >= mod / 2) ? int'(a) - mod : int'(a);
        sb  = (int'(b) >= mod / 2) ? int'(b) - mod : int'(b);
        sr  = sa - sb - int'(bin);
        res[7:0] = 8'(((r % mod) + mod) % mod);
        res[8]   = (r < 0);
        res[9]   = (sr < -(mod / 2)) || (sr > (mod / 2) - 1);
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one operation, confirms acceptance, waits for the result and checks it.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bin);
        logic [9:0] e;
        int lat;
        int w;
        w = sel ? 8 : 4;
        e = ref_sub(w, a, b, bin);
        @(posedge clk); #1;
        d_a = a; d_b = b; d_bin = bin; d_valid = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, obs_in_ready, 1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!obs_out_valid && lat < 50);
        check({tag, "_latency"}, lat, w + 1);
        check({tag, "_diff"}, obs_diff, e[7:0]);
        check({tag, "_bout"}, obs_bout, e[8]);
`ifdef SUB_OVF_EN
        check({tag, "_ovf"}, obs_ovf, e[9]);
`endif
    endtask

    task automatic release_result(input string tag);
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        d_out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_released"}, obs_out_valid, 0);
        check({tag, "_idle_ready"}, obs_in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e;
        bit acc;
        int cyc, last_acc, n_sent, n_recv;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", if4.in_ready, 1);
        check("rst_out_valid", if4.out_valid, 0);
        check("rst_diff", if4.diff, 0);
        check("rst_bout", if4.bout, 0);
        check("rst_state", if4.dbg_state, ST_IDLE);
`ifdef SUB_OVF_EN
        check("rst_ovf", if4.ovf, 0);
`endif
        #1 rst_n = 1'b1;

        // Directed WIDTH=4 cases
        run_op("zero", 8'h0, 8'h0, 1'b0);
        release_result("zero");
        run_op("five_minus_three", 8'h5, 8'h3, 1'b0);
        release_result("five_minus_three");
        run_op("one_minus_f_b1", 8'h1, 8'hF, 1'b1);
        release_result("one_minus_f_b1");
        run_op("full_wrap", 8'h0, 8'hF, 1'b1);
        release_result("full_wrap");

        // Signed overflow case held in DONE with in_valid pulses that must be ignored
        run_op("hold", 8'h8, 8'h1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            d_valid = 1'($urandom_range(0, 1));
            d_a = 8'($urandom); d_b = 8'($urandom); d_bin = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_out_valid", obs_out_valid, 1);
            check("hold_in_ready", obs_in_ready, 0);
            check("hold_diff", obs_diff, 8'h7);
            check("hold_bout", obs_bout, 0);
        end
        @(posedge clk); #1;
        d_valid = 1'b0;
        @(negedge clk);
        release_result("hold");

        // Reset two cycles into SHIFT aborts the operation at once
        @(posedge clk); #1;
        d_a = 8'h5; d_b = 8'h3; d_bin = 1'b0; d_valid = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", if4.out_valid, 0);
        check("abort_in_ready", if4.in_ready, 1);
        check("abort_diff", if4.diff, 0);
        check("abort_bout", if4.bout, 0);
        check("abort_state", if4.dbg_state, ST_IDLE);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("after_abort", 8'hF, 8'hF, 1'b1);
        release_result("after_abort");

        // Random WIDTH=8 traffic; first N_BB ops back-to-back to check the accept interval
        sel = 1'b1;
        cyc = 0; last_acc = -1; n_sent = 0; n_recv = 0;
        @(posedge clk); #1;
        d_a = 8'($urandom); d_b = 8'($urandom); d_bin = 1'($urandom_range(0, 1));
        d_valid = 1'b1;
        d_out_ready = 1'b1;
        while (n_recv < N_OPS && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (obs_out_valid && d_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_diff", obs_diff, e[7:0]);
                    check("rnd_bout", obs_bout, e[8]);
`ifdef SUB_OVF_EN
                    check("rnd_ovf", obs_ovf, e[9]);
`endif
                    n_recv++;
                end
            end
            acc = d_valid && obs_in_ready;
            if (acc) begin
                exp_q.push_back(ref_sub(8, d_a, d_b, d_bin));
                if (n_sent < N_BB && last_acc >= 0)
                    check("rnd_interval", cyc - last_acc, 10);
                last_acc = cyc;
                n_sent++;
            end
            @(posedge clk); #1;
            if (acc || !d_valid) begin
                d_a = 8'($urandom); d_b = 8'($urandom); d_bin = 1'($urandom_range(0, 1));
                d_valid = (n_sent < N_BB) || (n_sent < N_OPS && $urandom_range(0, 3) != 0);
            end
            d_out_ready = (n_sent <= N_BB) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        d_valid = 1'b0;
        d_out_ready = 1'b0;
        check("rnd_all_received", n_recv, N_OPS);
        check("rnd_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
